// File: rtl/image_spike_streamer.sv
// Captures a binary image on iSTART and streams the index of every set pixel, NUM_STEPS times,
// each pass closed by an end-of-step beat. Optional per-step accepted-spike counter: SPK_COUNT_EN.
module image_spike_streamer #(
   parameter int IMG_BITS  = 784,
   parameter int IDX_W     = 10,
   parameter int NUM_STEPS = 4,
   parameter int STEP_W    = 2
) (
   input  logic                iCLK,
   input  logic                iRESET,
   input  logic [IMG_BITS-1:0] iIMAGE,
   input  logic                iSTART,
   output logic                oBUSY,
   output logic                oSPK_VALID,
   input  logic                iSPK_READY,
   output logic [IDX_W-1:0]    oSPK_IDX,
   output logic [STEP_W-1:0]   oSPK_STEP,
   output logic                oSPK_EOS,
   output logic                oDONE
`ifdef SPK_COUNT_EN
   ,
   output logic [IDX_W:0]      oSPK_COUNT
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_EMIT,
      S_EOS,
      S_DONE
   } state_t;

   localparam logic [IDX_W-1:0]  P_LAST = IDX_W'(IMG_BITS - 1);
   localparam logic [STEP_W-1:0] S_LAST = STEP_W'(NUM_STEPS - 1);

   state_t                state_q, state_d;
   logic [IMG_BITS-1:0]   img_q, img_d;
   logic [IDX_W-1:0]      p_q, p_d;
   logic [STEP_W-1:0]     s_q, s_d;

   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         state_q <= S_IDLE;
         img_q   <= '0;
         p_q     <= '0;
         s_q     <= '0;
      end else begin
         state_q <= state_d;
         img_q   <= img_d;
         p_q     <= p_d;
         s_q     <= s_d;
      end
   end

   always_comb begin
      state_d = state_q;
      img_d   = img_q;
      p_d     = p_q;
      s_d     = s_q;
      unique case (state_q)
         S_IDLE: begin
            if (iSTART) begin
               img_d   = iIMAGE;
               p_d     = '0;
               s_d     = '0;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (img_q[p_q]) begin
               state_d = S_EMIT;
            end else if (p_q == P_LAST) begin
               state_d = S_EOS;
            end else begin
               p_d = p_q + 1'b1;
            end
         end
         S_EMIT: begin
            if (iSPK_READY) begin
               if (p_q == P_LAST) begin
                  state_d = S_EOS;
               end else begin
                  p_d     = p_q + 1'b1;
                  state_d = S_SCAN;
               end
            end
         end
         S_EOS: begin
            if (iSPK_READY) begin
               if (s_q == S_LAST) begin
                  state_d = S_DONE;
               end else begin
                  s_d     = s_q + 1'b1;
                  p_d     = '0;
                  state_d = S_SCAN;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Beat fields are forced to zero whenever no beat is presented.
   always_comb begin
      oBUSY      = (state_q != S_IDLE);
      oSPK_VALID = (state_q == S_EMIT) || (state_q == S_EOS);
      oSPK_EOS   = (state_q == S_EOS);
      oSPK_IDX   = (state_q == S_EMIT) ? p_q : '0;
      oSPK_STEP  = oSPK_VALID ? s_q : '0;
      oDONE      = (state_q == S_DONE);
   end

`ifdef SPK_COUNT_EN
   localparam logic [IDX_W:0] CNT_MAX = (IDX_W + 1)'(IMG_BITS);

   logic [IDX_W:0] cnt_q, cnt_d;

   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if ((state_q == S_IDLE) && iSTART) begin
         cnt_d = '0;
      end else if ((state_q == S_EOS) && iSPK_READY) begin
         cnt_d = '0;
      end else if ((state_q == S_EMIT) && iSPK_READY && (cnt_q < CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign oSPK_COUNT = cnt_q;
`endif

endmodule
